// File: rtl/return_addr_stack.sv
// Return-address stack: JAL pushes its link address in ID, JR $ra pops an early
// predicted target, and the prediction is checked when the JR resolves in EX.
module return_addr_stack #(
   parameter int PC_WIDTH = 32,
   parameter int DEPTH    = 8,
   parameter int PTR_W    = 3
) (
   input  logic                ras_i_clk,
   input  logic                ras_i_rst_n,
   input  logic                ras_i_stall,
   input  logic                ras_i_flush,
   input  logic                ras_i_push,
   input  logic [PC_WIDTH-1:0] ras_i_push_addr,
   input  logic                ras_i_pop,
   input  logic                ras_i_resolve,
   input  logic [PC_WIDTH-1:0] ras_i_actual_addr,
   output logic [PC_WIDTH-1:0] ras_o_pc,
   output logic                ras_o_change_pc,
   output logic                ras_o_busy,
   output logic                ras_o_mispredict,
   output logic [PC_WIDTH-1:0] ras_o_correct_pc,
   output logic [PTR_W:0]      ras_o_count
);

   typedef enum logic {IDLE, PENDING} state_t;

   localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

   state_t              r_state;
   state_t              w_nextState;
   logic [PC_WIDTH-1:0] r_stack [DEPTH];
   logic [PTR_W-1:0]    r_top;
   logic [PTR_W:0]      r_count;
   logic [PC_WIDTH-1:0] r_pred;
   logic                r_predValid;

   logic                w_pushEn;
   logic                w_popEn;
   logic                w_popHit;
   logic                w_resolveEn;
   logic                w_match;
   logic [PTR_W-1:0]    w_topM1;
   logic [PC_WIDTH-1:0] w_topEntry;

   // Flush squashes everything; stall only holds the ID-side push/pop.
   assign w_pushEn    = ras_i_push && !ras_i_stall && !ras_i_flush;
   assign w_popEn     = ras_i_pop && !ras_i_stall && !ras_i_flush && (r_state == IDLE);
   assign w_popHit    = w_popEn && (r_count != '0);
   assign w_resolveEn = ras_i_resolve && !ras_i_flush && (r_state == PENDING);
   assign w_topM1     = r_top - PTR_W'(1);
   assign w_topEntry  = r_stack[w_topM1];
   assign w_match     = r_predValid && (r_pred == ras_i_actual_addr);

   always_ff @(posedge ras_i_clk or negedge ras_i_rst_n) begin
      if (!ras_i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_popEn) w_nextState = PENDING;
         PENDING: if (ras_i_resolve || ras_i_flush) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // A push paired with a non-empty pop replaces the popped slot in place.
   always_ff @(posedge ras_i_clk or negedge ras_i_rst_n) begin
      if (!ras_i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stack[i] <= '0;
         end
         r_top       <= '0;
         r_count     <= '0;
         r_pred      <= '0;
         r_predValid <= 1'b0;
      end else begin
         if (w_pushEn && w_popHit) begin
            r_stack[w_topM1] <= ras_i_push_addr;
         end else if (w_pushEn) begin
            r_stack[r_top] <= ras_i_push_addr;
            r_top          <= r_top + PTR_W'(1);
            if (r_count != L_FULL) begin
               r_count <= r_count + (PTR_W+1)'(1);
            end
         end else if (w_popHit) begin
            r_top   <= w_topM1;
            r_count <= r_count - (PTR_W+1)'(1);
         end
         if (w_popEn) begin
            r_predValid <= w_popHit;
            if (w_popHit) begin
               r_pred <= w_topEntry;
            end
         end
      end
   end

   always_comb begin
      ras_o_pc         = '0;
      ras_o_change_pc  = 1'b0;
      ras_o_mispredict = 1'b0;
      ras_o_correct_pc = '0;
      ras_o_busy       = (r_state == PENDING);
      ras_o_count      = r_count;
      if (w_popHit) begin
         ras_o_pc        = w_topEntry;
         ras_o_change_pc = 1'b1;
      end
      if (w_resolveEn && !w_match) begin
         ras_o_mispredict = 1'b1;
         ras_o_correct_pc = ras_i_actual_addr;
      end
   end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed vector bench for return_addr_stack: a table of per-cycle inputs with
// hand-computed outputs, plus overflow and async-reset sequences.
module tb_return_addr_stack;

   logic        clk;
   logic        rstN;
   logic        stall;
   logic        flush;
   logic        push;
   logic [31:0] pushAddr;
   logic        pop;
   logic        resolve;
   logic [31:0] actualAddr;
   logic [31:0] pc;
   logic        changePc;
   logic        busy;
   logic        mispredict;
   logic [31:0] correctPc;
   logic [3:0]  count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        push;
      logic [31:0] pushAddr;
      logic        pop;
      logic        resolve;
      logic [31:0] actual;
      logic [31:0] expPc;
      logic        expChange;
      logic        expBusy;
      logic        expMisp;
      logic [31:0] expCorrect;
      logic [3:0]  expCount;
   } vec_t;

   vec_t vecs[$];

   return_addr_stack #(.PC_WIDTH(32), .DEPTH(8), .PTR_W(3)) dut (
      .ras_i_clk         (clk),
      .ras_i_rst_n       (rstN),
      .ras_i_stall       (stall),
      .ras_i_flush       (flush),
      .ras_i_push        (push),
      .ras_i_push_addr   (pushAddr),
      .ras_i_pop         (pop),
      .ras_i_resolve     (resolve),
      .ras_i_actual_addr (actualAddr),
      .ras_o_pc          (pc),
      .ras_o_change_pc   (changePc),
      .ras_o_busy        (busy),
      .ras_o_mispredict  (mispredict),
      .ras_o_correct_pc  (correctPc),
      .ras_o_count       (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic st, logic fl, logic pu, logic [31:0] pa,
                               logic po, logic rs, logic [31:0] ac,
                               logic [31:0] ePc, logic eCh, logic eBusy,
                               logic eMisp, logic [31:0] eCorr, logic [3:0] eCnt);
      vec_t v;
      v.stall = st;  v.flush = fl;  v.push = pu;  v.pushAddr = pa;
      v.pop = po;    v.resolve = rs; v.actual = ac;
      v.expPc = ePc; v.expChange = eCh; v.expBusy = eBusy;
      v.expMisp = eMisp; v.expCorrect = eCorr; v.expCount = eCnt;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(vec_t v);
      @(negedge clk);
      stall      = v.stall;
      flush      = v.flush;
      push       = v.push;
      pushAddr   = v.pushAddr;
      pop        = v.pop;
      resolve    = v.resolve;
      actualAddr = v.actual;
      #2;
   endtask

   task automatic checkOutput(string tag, vec_t v);
      chk({tag, ".pc"},         pc,                 v.expPc);
      chk({tag, ".change_pc"},  {31'd0, changePc},  {31'd0, v.expChange});
      chk({tag, ".busy"},       {31'd0, busy},      {31'd0, v.expBusy});
      chk({tag, ".mispredict"}, {31'd0, mispredict},{31'd0, v.expMisp});
      chk({tag, ".correct_pc"}, correctPc,          v.expCorrect);
      chk({tag, ".count"},      {28'd0, count},     {28'd0, v.expCount});
   endtask

   initial begin
      vec_t z;
      rstN = 1'b0;
      z = mk(0,0,0,0, 0,0,0, 0,0,0,0,0,0);
      stall = 0; flush = 0; push = 0; pushAddr = 0; pop = 0; resolve = 0; actualAddr = 0;

      // Fields: stall flush push pushAddr pop resolve actual | pc chg busy misp corr count(pre-edge)
      vecs.push_back(mk(0,0,1,32'h0040_0010, 0,0,0,            0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,             1,0,0,            32'h0040_0010,1,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,             0,1,32'h0040_0010,0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,             0,0,0,            0,0,0,0,0,0));
      vecs.push_back(mk(0,0,1,32'h100, 0,0,0,       0,0,0,0,0,0));
      vecs.push_back(mk(0,0,1,32'h200, 0,0,0,       0,0,0,0,0,1));
      vecs.push_back(mk(0,0,1,32'h300, 0,0,0,       0,0,0,0,0,2));
      vecs.push_back(mk(0,0,0,0,       1,0,0,       32'h300,1,0,0,0,3));
      vecs.push_back(mk(0,0,0,0,       0,1,32'h300, 0,0,1,0,0,2));
      vecs.push_back(mk(0,0,0,0,       1,0,0,       32'h200,1,0,0,0,2));
      vecs.push_back(mk(0,0,0,0,       0,1,32'h200, 0,0,1,0,0,1));
      vecs.push_back(mk(0,0,0,0,       1,0,0,       32'h100,1,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,       0,1,32'h100, 0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,       0,0,0,0,0,0));
      // empty pop, then resolve must redirect
      vecs.push_back(mk(0,0,0,0,       1,0,0,        0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,       0,1,32'h1234, 0,0,1,1,32'h1234,0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,        0,0,0,0,0,0));
      // wrong prediction, second pop ignored while pending
      vecs.push_back(mk(0,0,1,32'h500, 0,0,0,        0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,       1,0,0,        32'h500,1,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,       1,0,0,        0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,       0,1,32'h504,  0,0,1,1,32'h504,0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,        0,0,0,0,0,0));
      // flush dominates push and resolve
      vecs.push_back(mk(0,0,1,32'h700, 0,0,0,        0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,       1,0,0,        32'h700,1,0,0,0,1));
      vecs.push_back(mk(0,1,1,32'h600, 0,1,32'h999,  0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,        0,0,0,0,0,0));
      // stall blocks push; resolve still acts while stalled
      vecs.push_back(mk(1,0,1,32'h800, 0,0,0,        0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,        0,0,0,0,0,0));
      vecs.push_back(mk(0,0,1,32'h900, 0,0,0,        0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,       1,0,0,        32'h900,1,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,       1,1,32'h901,  0,0,1,1,32'h901,0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,        0,0,0,0,0,0));
      // push and pop together replace the top entry
      vecs.push_back(mk(0,0,1,32'hA00, 0,0,0,        0,0,0,0,0,0));
      vecs.push_back(mk(0,0,1,32'hB00, 1,0,0,        32'hA00,1,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,       0,1,32'hA00,  0,0,1,0,0,1));
      vecs.push_back(mk(0,0,0,0,       1,0,0,        32'hB00,1,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,       0,1,32'hB00,  0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,       0,0,0,        0,0,0,0,0,0));

      #3;
      checkOutput("reset", z);
      @(negedge clk);
      rstN = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      // overflow: nine pushes into eight entries, 0x04 is lost
      for (int i = 0; i < 9; i++) begin
         applyStimulus(mk(0,0,1,32'h04 + 32'(4*i), 0,0,0, 0,0,0,0,0,4'(i)));
         checkOutput($sformatf("ovf_push%0d", i), mk(0,0,1,0,0,0,0, 0,0,0,0,0,4'(i)));
      end
      applyStimulus(z);
      checkOutput("ovf_full", mk(0,0,0,0,0,0,0, 0,0,0,0,0,4'd8));
      for (int i = 0; i < 8; i++) begin
         vec_t p;
         vec_t r;
         p = mk(0,0,0,0, 1,0,0, 32'h24 - 32'(4*i),1,0,0,0,4'(8-i));
         r = mk(0,0,0,0, 0,1,32'h24 - 32'(4*i), 0,0,1,0,0,4'(7-i));
         applyStimulus(p);
         checkOutput($sformatf("ovf_pop%0d", i), p);
         applyStimulus(r);
         checkOutput($sformatf("ovf_res%0d", i), r);
      end
      applyStimulus(z);
      checkOutput("ovf_empty", z);

      // async reset while a mispredicting resolve is on the inputs
      applyStimulus(mk(0,0,1,32'hC00, 0,0,0, 0,0,0,0,0,0));
      applyStimulus(mk(0,0,0,0, 1,0,0, 32'hC00,1,0,0,0,1));
      applyStimulus(mk(0,0,0,0, 0,1,32'hDEAD, 0,0,1,1,32'hDEAD,0));
      checkOutput("pre_reset", mk(0,0,0,0,0,0,0, 0,0,1,1,32'hDEAD,0));
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("async_reset", z);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(z);
      checkOutput("post_reset", z);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Return-address stack (RAS) for the MIPS pipeline; it is the consumer side of JAL linkage.
- JAL pushes its link address (PC+4) in ID; JR $ra pops in ID to get an early predicted target.
- When the JR reaches EX with the true register value, the block verifies the prediction and raises a redirect on mismatch.
- Sits beside the ID-stage jump logic; drives the PC-select mux together with the JAL target path.

Parameters:
- PC_WIDTH, 32, width of PC and stored addresses
- DEPTH, 8, stack entries (power of two)
- PTR_W, 3, log2(DEPTH)

Ports:
- ras_i_clk  input  1  clock, rising edge
- ras_i_rst_n  input  1  asynchronous active-low reset
- ras_i_stall  input  1  pipeline stall; gates push and pop
- ras_i_flush  input  1  squash wrong-path JR in flight
- ras_i_push  input  1  JAL in ID
- ras_i_push_addr  input  PC_WIDTH  link address (JAL PC+4)
- ras_i_pop  input  1  JR $ra in ID
- ras_i_resolve  input  1  pending JR reaches EX
- ras_i_actual_addr  input  PC_WIDTH  forwarded $ra value at EX
- ras_o_pc  output  PC_WIDTH  predicted JR target
- ras_o_change_pc  output  1  take ras_o_pc this cycle
- ras_o_busy  output  1  JR pending; ID must stall further pops
- ras_o_mispredict  output  1  redirect required
- ras_o_correct_pc  output  PC_WIDTH  redirect target
- ras_o_count  output  PTR_W+1  valid entries

Behaviour:
- Reset (async, ras_i_rst_n=0):
  - count=0, top=0, all entries 0, FSM=IDLE, pred register 0, pred_valid=0.
  - All outputs 0 while in reset.
- Storage:
  - Circular array of DEPTH entries; top points to the next free slot; pointer arithmetic is mod DEPTH.
- Push (push & !stall & !flush):
  - Write push_addr at top; top+1.
  - count+1, saturating at DEPTH. When full, the oldest entry is silently overwritten (wrap).
- Pop (pop & !stall & !flush & FSM==IDLE), combinational in the same cycle:
  - If count>0: ras_o_pc = entry[top-1], ras_o_change_pc=1.
  - If count==0: ras_o_pc=0, ras_o_change_pc=0.
- Pop at the clock edge:
  - If count>0: top-1 and count-1; latch the predicted value, pred_valid=1.
  - If count==0: pred_valid=0.
  - FSM goes to PENDING.
- Push and pop in the same cycle:
  - The pop reads the old top. The push then writes slot top-1 (replaces the popped entry).
  - top and count are unchanged; the prediction is the old top.
- Pop while PENDING: ignored (no change_pc, no pointer change). ras_o_busy=1 throughout PENDING.
- FSM states: IDLE and PENDING.
  - IDLE -> PENDING on an accepted pop.
  - PENDING -> IDLE on resolve or flush.
- Resolve in PENDING (combinational outputs in the resolve cycle):
  - If pred_valid and pred == actual_addr: mispredict=0.
  - Otherwise: mispredict=1 and correct_pc=actual_addr, for exactly one cycle.
  - Stack is not repaired after a mispredict.
- Resolve in IDLE: ignored, mispredict=0.
- Flush:
  - Dominates push, pop and resolve in the same cycle; all three are ignored.
  - PENDING -> IDLE with no mispredict; pointers are not restored.
- Stall:
  - Blocks push and pop only.
  - Resolve and flush still act while stalled.
- Outputs when not driven by an event: ras_o_pc=0, change_pc=0, mispredict=0, correct_pc=0.

Test Plan:
- Reset, then push 0x0040_0010 then pop → same-cycle change_pc=1, pc=0x0040_0010, count 1→0; resolve with actual 0x0040_0010 → mispredict=0, FSM returns IDLE.
- Nested calls: push 0x100, 0x200, 0x300, then three pop/resolve pairs → predictions 0x300, 0x200, 0x100 in order; count ends at 0.
- Overflow at DEPTH=8: push 0x04..0x24 in steps of 4 (9 pushes) → count=8; eight pops predict 0x24 down to 0x08; 0x04 is lost.
- Empty pop → change_pc=0; resolve with actual 0x1234 → mispredict=1, correct_pc=0x1234 for one cycle.
- Wrong prediction: push 0x500, pop, resolve actual 0x504 → mispredict=1, correct_pc=0x504. A second pop asserted while PENDING is ignored with busy=1.
- Flush while PENDING, asserted together with push 0x600 → no mispredict, FSM IDLE, push dropped, count unchanged. Also: async reset mid-PENDING → all outputs 0 immediately.
